// File: rtl/ring_arb_pkg.sv
// Shared definitions for the ring round-robin arbiter: FSM encoding,
// default parameters and a one-hot to index helper.
package ring_arb_pkg;

  localparam int DEF_N        = 3;
  localparam int DEF_MAX_HOLD = 8;
  localparam int MAX_N        = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arbState_t;

  function automatic logic [2:0] onehotToIdx(input logic [MAX_N-1:0] oneHot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oneHot[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_ptr.sv
// One-hot rotating priority pointer; loading an index moves the single set
// bit to that slot.
module ring_ptr #(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic [$clog2(N)-1:0] i_idx,
  output logic [N-1:0]         o_ptr
);

  logic [N-1:0] r_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= N'(1);
    end else if (i_load) begin
      r_ptr <= N'(1) << i_idx;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot priority ring, registered one-hot grant,
// no preemption and a forced release after MAX_HOLD cycles of ownership.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] owner,
  output logic                 timeout
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  arbState_t      r_state;
  logic [N-1:0]   r_grant;
  logic           r_grantValid;
  logic [IW-1:0]  r_owner;
  logic           r_timeout;
  logic [HW-1:0]  r_holdCnt;

  logic [N-1:0]   w_ptr;
  logic [2:0]     w_ptrIdx;
  logic           w_found;
  logic [IW-1:0]  w_selIdx;
  logic [N-1:0]   w_selOneHot;
  logic           w_ownDone;
  logic           w_ownReq;
  logic           w_expired;
  logic           w_release;
  logic [IW-1:0]  w_nextIdx;

  ring_ptr #(.N(N)) u_ptr (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_release),
    .i_idx  (w_nextIdx),
    .o_ptr  (w_ptr)
  );

  assign w_ptrIdx = onehotToIdx(MAX_N'(w_ptr));

  // Wrapped scan: descending k so the slot closest to ptr wins last.
  always_comb begin
    logic [IW-1:0] cand;
    w_found  = 1'b0;
    w_selIdx = '0;
    cand     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(w_ptrIdx) + k) % N);
      if (req[cand]) begin
        w_found  = 1'b1;
        w_selIdx = cand;
      end
    end
  end

  assign w_selOneHot = N'(1) << w_selIdx;
  assign w_ownDone   = done[r_owner];
  assign w_ownReq    = req[r_owner];
  assign w_expired   = (r_holdCnt == HW'(MAX_HOLD));
  assign w_release   = (r_state == ST_GRANT) && (w_ownDone || !w_ownReq || w_expired);
  assign w_nextIdx   = (r_owner == IW'(N - 1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_grantValid <= 1'b0;
      r_owner      <= '0;
      r_timeout    <= 1'b0;
      r_holdCnt    <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state      <= ST_GRANT;
            r_grant      <= w_selOneHot;
            r_grantValid <= 1'b1;
            r_owner      <= w_selIdx;
            r_holdCnt    <= HW'(1);
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_grantValid <= 1'b0;
            r_holdCnt    <= '0;
            // Timeout only when expiry alone forced the release.
            r_timeout    <= w_expired && w_ownReq && !w_ownDone;
          end else begin
            r_holdCnt <= r_holdCnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grantValid;
  assign owner       = r_owner;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Bench for ring_rr_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an ownership-level model.
module tb_ring_rr_arbiter;

  localparam int N        = 3;
  localparam int MAX_HOLD = 8;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   owner;
  logic         timeout;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEn     = 0;

  // Model: current owner (-1 when idle), last owner, cycles held, priority slot.
  int mOwner   = -1;
  int mLast    = 0;
  int mHold    = 0;
  int mPtr     = 0;
  bit mTimeout = 0;
  int runLen   = 0;

  logic [2:0] expSeq [4];
  int         expOwn [4];

  ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .owner       (owner),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] d);
    @(negedge clk);
    req  = r;
    done = d;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mOwner   = -1;
      mLast    = 0;
      mHold    = 0;
      mPtr     = 0;
      mTimeout = 0;
    end else begin
      mTimeout = 0;
      if (mOwner < 0) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (mPtr + k) % N;
          if (req[j] && mOwner < 0) begin
            mOwner = j;
            mLast  = j;
            mHold  = 1;
          end
        end
      end else if (done[mOwner] || !req[mOwner]) begin
        mPtr   = (mOwner + 1) % N;
        mOwner = -1;
      end else if (mHold == MAX_HOLD) begin
        mPtr     = (mOwner + 1) % N;
        mOwner   = -1;
        mTimeout = 1;
      end else begin
        mHold++;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_grant", 32'(grant), (mOwner >= 0) ? (32'd1 << mOwner) : 32'd0);
      checkOutput("model_valid", 32'(grant_valid), (mOwner >= 0) ? 32'd1 : 32'd0);
      checkOutput("model_owner", 32'(owner), 32'(mLast));
      checkOutput("model_timeout", 32'(timeout), 32'(mTimeout));
      runLen = (grant !== '0) ? runLen + 1 : 0;
      checkOutput("hold_bound", 32'(runLen > MAX_HOLD), 32'd0);
    end
  end

  initial begin
    expSeq = '{3'b001, 3'b010, 3'b100, 3'b001};
    expOwn = '{0, 1, 2, 0};
    reset = 1'b1;
    req   = '0;
    done  = '0;
    #1 checkEn = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_valid", 32'(grant_valid), 32'd0);
    checkOutput("rst_owner", 32'(owner), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    req   = 3'b111;

    // Full rotation with done in the second grant cycle of each ownership.
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      checkOutput("seq_grant_c1", 32'(grant), 32'(expSeq[g]));
      @(negedge clk);
      checkOutput("seq_grant_c2", 32'(grant), 32'(expSeq[g]));
      done = expSeq[g];
      @(negedge clk);
      checkOutput("seq_gap", 32'(grant), 32'd0);
      checkOutput("seq_owner", 32'(owner), 32'(expOwn[g]));
      done = '0;
      if (g == 3) req = '0;
    end

    // Requester 1 holds until MAX_HOLD expiry.
    applyStimulus(3'b010, 3'b000);
    for (int i = 0; i < MAX_HOLD; i++) begin
      @(negedge clk);
      checkOutput("to_hold", 32'(grant), 32'h2);
    end
    @(negedge clk);
    checkOutput("to_release", 32'(grant), 32'd0);
    checkOutput("to_pulse", 32'(timeout), 32'd1);
    req = '0;
    @(negedge clk);
    checkOutput("to_pulse_end", 32'(timeout), 32'd0);

    // Owner 2 abandons in its third grant cycle.
    applyStimulus(3'b100, 3'b000);
    @(negedge clk);
    checkOutput("ab_c1", 32'(grant), 32'h4);
    @(negedge clk);
    checkOutput("ab_c2", 32'(grant), 32'h4);
    @(negedge clk);
    checkOutput("ab_c3", 32'(grant), 32'h4);
    req = 3'b011;
    @(negedge clk);
    checkOutput("ab_gap", 32'(grant), 32'd0);
    checkOutput("ab_no_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    checkOutput("ab_next", 32'(grant), 32'h1);
    req = '0;
    @(negedge clk);
    checkOutput("ab_next_rel", 32'(grant), 32'd0);

    // done[2] coincides with hold expiry.
    applyStimulus(3'b100, 3'b000);
    for (int i = 0; i < MAX_HOLD; i++) begin
      @(negedge clk);
      checkOutput("both_hold", 32'(grant), 32'h4);
      if (i == MAX_HOLD - 1) done = 3'b100;
    end
    @(negedge clk);
    checkOutput("both_release", 32'(grant), 32'd0);
    checkOutput("both_timeout", 32'(timeout), 32'd0);
    req  = '0;
    done = '0;
    @(negedge clk);
    checkOutput("both_timeout_after", 32'(timeout), 32'd0);

    // Asynchronous reset while 3'b100 is granted.
    applyStimulus(3'b100, 3'b000);
    @(negedge clk);
    checkOutput("ar_pre", 32'(grant), 32'h4);
    #2 reset = 1'b1;
    #1;
    checkOutput("ar_grant", 32'(grant), 32'd0);
    checkOutput("ar_valid", 32'(grant_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    req   = 3'b110;
    @(negedge clk);
    checkOutput("ar_post", 32'(grant), 32'h2);

    // Non-owner done is ignored.
    done = 3'b001;
    @(negedge clk);
    checkOutput("ign_hold", 32'(grant), 32'h2);
    done = 3'b010;
    @(negedge clk);
    checkOutput("ign_release", 32'(grant), 32'd0);
    checkOutput("ign_owner", 32'(owner), 32'd1);
    req  = '0;
    done = '0;

    // Randomized traffic; inputs move mid-low-phase to stay clear of the compare.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #2;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 7));
      done = ($urandom_range(0, 5) == 0) ? N'($urandom_range(0, 7)) : '0;
    end
    @(negedge clk);
    checkEn = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
